multicycle_cpu: RTL

//  Parametrised multi-cycle successor to the single-cycle 16-bit CPU top.

---
 rtl/multicycle_cpu.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_cpu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicycle_cpu                                                       |
// | FETCH/DECODE/EXECUTE/WRITEBACK CPU with loadable program memory.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module multicycle_cpu #(
    parameter int DATA_W     = 16,
    parameter int PROG_DEPTH = 16,
    parameter int REG_COUNT  = 16,
    localparam int PC_W      = $clog2(PROG_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [15:0]       prog_wdata,
    output logic [DATA_W-1:0] result,
    output logic              cout,
    output logic              overflow,
    output logic              NO,
    output logic              ZO,
    output logic              busy,
    output logic              halted
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_fetch  = 3'd1;
    localparam logic [2:0] c_st_decode = 3'd2;
    localparam logic [2:0] c_st_exec   = 3'd3;
    localparam logic [2:0] c_st_wb     = 3'd4;
    localparam logic [2:0] c_st_halt   = 3'd5;

    logic [2:0]        r_state;
    logic [PC_W-1:0]   r_pc;
    logic [15:0]       r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;
    logic              r_cout;
    logic              r_ovf;
    logic              r_no;
    logic              r_zo;
    logic              r_busy;
    logic              r_halted;
    logic [DATA_W-1:0] r_regs [REG_COUNT];
    logic [15:0]       r_mem  [PROG_DEPTH];

    logic [3:0]        w_op;
    logic [3:0]        w_rd;
    logic [3:0]        w_ra;
    logic [3:0]        w_rb;
    logic [PC_W-1:0]   w_target;
    logic              w_writes;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_res;
    logic              w_c;
    logic              w_v;

    assign w_op     = r_ir[15:12];
    assign w_rd     = r_ir[11:8];
    assign w_ra     = r_ir[7:4];
    assign w_rb     = r_ir[3:0];
    assign w_target = r_ir[PC_W-1:0];
    assign w_writes = (w_op <= 4'd8);

    always_comb begin
        w_sum  = {1'b0, r_a} + {1'b0, r_b};
        w_diff = {1'b0, r_a} - {1'b0, r_b};
        w_res  = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (w_op)
            4'd0: begin
                w_res = w_sum[DATA_W-1:0];
                w_c   = w_sum[DATA_W];
                w_v   = (r_a[DATA_W-1] == r_b[DATA_W-1]) && (w_res[DATA_W-1] != r_a[DATA_W-1]);
            end
            4'd1: begin
                // Carry reads as "no borrow" for subtraction
                w_res = w_diff[DATA_W-1:0];
                w_c   = ~w_diff[DATA_W];
                w_v   = (r_a[DATA_W-1] != r_b[DATA_W-1]) && (w_res[DATA_W-1] != r_a[DATA_W-1]);
            end
            4'd2: w_res = r_a & r_b;
            4'd3: w_res = r_a | r_b;
            4'd4: w_res = r_a ^ r_b;
            4'd5: w_res = ~r_a;
            4'd6: begin
                w_res = {r_a[DATA_W-2:0], 1'b0};
                w_c   = r_a[DATA_W-1];
            end
            4'd7: begin
                w_res = {1'b0, r_a[DATA_W-1:1]};
                w_c   = r_a[0];
            end
            4'd8: w_res = {{(DATA_W-8){1'b0}}, r_ir[7:0]};
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (prog_we && (r_state == c_st_idle || r_state == c_st_halt)) begin
            r_mem[prog_addr] <= prog_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_pc     <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_no     <= 1'b0;
            r_zo     <= 1'b0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                c_st_idle, c_st_halt: begin
                    if (run) begin
                        r_state  <= c_st_fetch;
                        r_pc     <= '0;
                        r_busy   <= 1'b1;
                        r_halted <= 1'b0;
                    end
                end
                c_st_fetch: begin
                    r_ir    <= r_mem[r_pc];
                    r_state <= c_st_decode;
                end
                c_st_decode: begin
                    r_a     <= r_regs[w_ra];
                    r_b     <= r_regs[w_rb];
                    r_state <= c_st_exec;
                end
                c_st_exec: begin
                    if (w_writes) begin
                        r_result <= w_res;
                        r_cout   <= w_c;
                        r_ovf    <= w_v;
                        r_no     <= w_res[DATA_W-1];
                        r_zo     <= (w_res == '0);
                    end
                    if (w_op == 4'hF) begin
                        r_state  <= c_st_halt;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= c_st_wb;
                    end
                end
                c_st_wb: begin
                    if (w_writes) begin
                        r_regs[w_rd] <= r_result;
                    end
                    // BZ sees ZO unchanged since it does not update flags
                    if (w_op == 4'h9 || (w_op == 4'hA && r_zo)) begin
                        r_pc <= w_target;
                    end else begin
                        r_pc <= r_pc + 1'b1;
                    end
                    r_state <= c_st_fetch;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_ovf;
    assign NO       = r_no;
    assign ZO       = r_zo;
    assign busy     = r_busy;
    assign halted   = r_halted;

endmodule
`default_nettype wire
